// File: rtl/chimera_pkg.sv
// rtl/chimera_pkg.sv - shared types and defaults for the cluster clock-gate sequencer
package chimera_pkg;

    localparam int unsigned ExtClusters      = 5;
    localparam int unsigned CluCntWidth      = 6;
    localparam int unsigned CluWakeCycles    = 4;
    localparam int unsigned CluTimeoutCycles = 1024;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } clu_gate_state_e;

endpackage

// File: rtl/chimera_clu_gate_fsm.sv
// rtl/chimera_clu_gate_fsm.sv - one cluster: txn counter, gate FSM, wake and drain-timeout counters
// Optional drain timeout enabled by CHIMERA_CLU_GATE_TIMEOUT_EN.
module chimera_clu_gate_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned CntWidth      = CluCntWidth,
    parameter int unsigned WakeCycles    = CluWakeCycles,
    parameter int unsigned TimeoutCycles = CluTimeoutCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic gate_req_i,
    input  logic txn_start_i,
    input  logic txn_done_i,
    output logic isolate_o,
    output logic clk_en_o,
    output logic gated_o,
    output logic timeout_err_o
);

    localparam int unsigned WakeW = $clog2(WakeCycles + 1);
    localparam logic [WakeW-1:0]    WakeLoad = WakeW'(WakeCycles - 1);
    localparam logic [CntWidth-1:0] CntMax   = '1;

    if (WakeCycles < 1 || TimeoutCycles < 2) begin : g_cfg_err
        $error("chimera_clu_gate_fsm: WakeCycles must be >= 1 and TimeoutCycles >= 2");
    end

    clu_gate_state_e     state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [WakeW-1:0]    wake_q, wake_d;
    logic                isolate_q, clk_en_q, gated_q;
    logic                tmo_hit, gate_block;

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;

    // Counts DRAIN cycles; saturates so a busy-but-empty drain cannot wrap.
    always_comb begin
        tmo_d = '0;
        if (state_q == DRAIN) begin
            tmo_d = (tmo_q == TmoLast) ? tmo_q : tmo_q + 1'b1;
        end
        tmo_hit = (state_q == DRAIN) && (tmo_q == TmoLast) && (cnt_q != '0);
        err_d   = err_q | tmo_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign gate_block    = err_q;
    assign timeout_err_o = err_q;
`else
    assign tmo_hit       = 1'b0;
    assign gate_block    = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wake_d  = wake_q;

        // The counter is frozen while gated: the cluster has no clock.
        if (state_q != GATED) begin
            if (txn_start_i && !txn_done_i && cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end else if (txn_done_i && !txn_start_i && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        unique case (state_q)
            RUN: begin
                if (gate_req_i && !gate_block) state_d = DRAIN;
            end
            DRAIN: begin
                if (!gate_req_i || tmo_hit) begin
                    state_d = RUN;
                end else if (cnt_d == '0 && !txn_start_i) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                if (!gate_req_i) begin
                    state_d = WAKE;
                    wake_d  = WakeLoad;
                end
            end
            WAKE: begin
                if (wake_q == '0) state_d = RUN;
                else              wake_d  = wake_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            wake_q    <= '0;
            isolate_q <= 1'b0;
            clk_en_q  <= 1'b1;
            gated_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wake_q    <= wake_d;
            isolate_q <= (state_d != RUN);
            clk_en_q  <= (state_d != GATED);
            gated_q   <= (state_d == GATED);
        end
    end

    assign isolate_o = isolate_q;
    assign clk_en_o  = clk_en_q;
    assign gated_o   = gated_q;

    a_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(txn_done_i && !txn_start_i && cnt_q == '0 && state_q != GATED))
        else $error("txn_done with no outstanding transaction");

    a_start_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(txn_start_i && !txn_done_i && cnt_q == CntMax && state_q != GATED))
        else $error("outstanding transaction counter saturated");

    a_traffic_gated: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((txn_start_i || txn_done_i) && state_q == GATED))
        else $error("transaction activity on a gated cluster");

endmodule

// File: rtl/chimera_clu_gate_ctrl.sv
// rtl/chimera_clu_gate_ctrl.sv - per-cluster clock-gate sequencer array
// Optional drain timeout enabled by CHIMERA_CLU_GATE_TIMEOUT_EN.
module chimera_clu_gate_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters   = ExtClusters,
    parameter int unsigned CntWidth      = CluCntWidth,
    parameter int unsigned WakeCycles    = CluWakeCycles,
    parameter int unsigned TimeoutCycles = CluTimeoutCycles
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumClusters-1:0] gate_req_i,
    input  logic [NumClusters-1:0] txn_start_i,
    input  logic [NumClusters-1:0] txn_done_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] gated_o,
    output logic [NumClusters-1:0] timeout_err_o
);

    for (genvar i = 0; i < NumClusters; i++) begin : g_clu
        chimera_clu_gate_fsm #(
            .CntWidth      (CntWidth),
            .WakeCycles    (WakeCycles),
            .TimeoutCycles (TimeoutCycles)
        ) u_fsm (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .gate_req_i    (gate_req_i[i]),
            .txn_start_i   (txn_start_i[i]),
            .txn_done_i    (txn_done_i[i]),
            .isolate_o     (isolate_o[i]),
            .clk_en_o      (clk_en_o[i]),
            .gated_o       (gated_o[i]),
            .timeout_err_o (timeout_err_o[i])
        );
    end

endmodule

// File: tb/tb_chimera_clu_gate_ctrl.sv
// tb/tb_chimera_clu_gate_ctrl.sv - directed self-checking bench for chimera_clu_gate_ctrl
module tb_chimera_clu_gate_ctrl;

    localparam int unsigned N = 5;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] gate_req_i, txn_start_i, txn_done_i;
    logic [N-1:0] isolate_o, clk_en_o, gated_o, timeout_err_o;

    int n_cmp = 0;
    int n_err = 0;

    chimera_clu_gate_ctrl #(
        .NumClusters   (N),
        .CntWidth      (6),
        .WakeCycles    (4),
        .TimeoutCycles (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .gate_req_i    (gate_req_i),
        .txn_start_i   (txn_start_i),
        .txn_done_i    (txn_done_i),
        .isolate_o     (isolate_o),
        .clk_en_o      (clk_en_o),
        .gated_o       (gated_o),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] iso, input logic [N-1:0] cen,
                           input logic [N-1:0] gtd);
        chk({tag, ".isolate"}, isolate_o, iso);
        chk({tag, ".clk_en"},  clk_en_o,  cen);
        chk({tag, ".gated"},   gated_o,   gtd);
    endtask

    initial begin
        rst_ni      = 1'b0;
        gate_req_i  = '0;
        txn_start_i = '0;
        txn_done_i  = '0;
        tick(3);
        chk_all("reset", 5'b00000, 5'b11111, 5'b00000);
        chk("reset.timeout_err", timeout_err_o, 5'b00000);
        rst_ni = 1'b1;
        tick();

        // Idle gate of cluster 2
        gate_req_i = 5'b00100;
        tick();
        chk_all("idle_gate+1", 5'b00100, 5'b11111, 5'b00000);
        tick();
        chk_all("idle_gate+2", 5'b00100, 5'b11011, 5'b00100);

        // Wake cluster 2; re-request mid-WAKE only takes effect after RUN
        gate_req_i = 5'b00000;
        tick();
        chk_all("wake+1", 5'b00100, 5'b11111, 5'b00000);
        gate_req_i = 5'b00100;
        tick();
        chk("wake+2.isolate", isolate_o, 5'b00100);
        tick();
        chk("wake+3.isolate", isolate_o, 5'b00100);
        tick();
        chk("wake+4.isolate", isolate_o, 5'b00100);
        tick();
        chk_all("wake+5.run", 5'b00000, 5'b11111, 5'b00000);
        tick();
        chk_all("rereq.drain", 5'b00100, 5'b11111, 5'b00000);
        tick();
        chk_all("rereq.gated", 5'b00100, 5'b11011, 5'b00100);
        gate_req_i = 5'b00000;
        tick(5);
        chk_all("rewake.run", 5'b00000, 5'b11111, 5'b00000);

        // Drain: 3 outstanding on cluster 0, dones 5 cycles apart
        txn_start_i = 5'b00001;
        tick(3);
        txn_start_i = 5'b00000;
        gate_req_i  = 5'b00001;
        tick();
        chk_all("drain.enter", 5'b00001, 5'b11111, 5'b00000);
        tick(4);
        txn_done_i = 5'b00001;
        tick();
        txn_done_i = 5'b00000;
        chk("drain.done1.clk_en", clk_en_o, 5'b11111);
        tick(4);
        txn_done_i = 5'b00001;
        tick();
        txn_done_i = 5'b00000;
        chk("drain.done2.clk_en", clk_en_o, 5'b11111);
        tick(4);
        chk("drain.pre_done3.clk_en", clk_en_o, 5'b11111);
        txn_done_i = 5'b00001;
        tick();
        txn_done_i = 5'b00000;
        chk_all("drain.done3", 5'b00001, 5'b11110, 5'b00001);
        gate_req_i = 5'b00000;
        tick(5);
        chk_all("drain.wake", 5'b00000, 5'b11111, 5'b00000);

        // Simultaneous start+done with one outstanding on cluster 1
        txn_start_i = 5'b00010;
        tick();
        txn_start_i = 5'b00000;
        gate_req_i  = 5'b00010;
        tick();
        chk("simul.enter.isolate", isolate_o, 5'b00010);
        txn_start_i = 5'b00010;
        txn_done_i  = 5'b00010;
        tick();
        txn_start_i = 5'b00000;
        txn_done_i  = 5'b00000;
        chk_all("simul.both", 5'b00010, 5'b11111, 5'b00000);
        txn_done_i = 5'b00010;
        tick();
        txn_done_i = 5'b00000;
        chk_all("simul.lone_done", 5'b00010, 5'b11101, 5'b00010);
        gate_req_i = 5'b00000;
        tick(5);
        chk_all("simul.wake", 5'b00000, 5'b11111, 5'b00000);

        // Abort from DRAIN with two outstanding on cluster 3
        txn_start_i = 5'b01000;
        tick(2);
        txn_start_i = 5'b00000;
        gate_req_i  = 5'b01000;
        tick();
        chk_all("abort.drain", 5'b01000, 5'b11111, 5'b00000);
        tick();
        chk("abort.hold.clk_en", clk_en_o, 5'b11111);
        gate_req_i = 5'b00000;
        tick();
        chk_all("abort.run", 5'b00000, 5'b11111, 5'b00000);
        txn_done_i = 5'b01000;
        tick(2);
        txn_done_i = 5'b00000;
        tick();
        chk_all("abort.settled", 5'b00000, 5'b11111, 5'b00000);

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
        // Drain timeout on cluster 4: one outstanding that never completes
        txn_start_i = 5'b10000;
        tick();
        txn_start_i = 5'b00000;
        gate_req_i  = 5'b10000;
        tick();
        chk("tmo.enter.isolate", isolate_o, 5'b10000);
        tick(15);
        chk("tmo.pre.err", timeout_err_o, 5'b00000);
        chk("tmo.pre.isolate", isolate_o, 5'b10000);
        tick();
        chk("tmo.hit.err", timeout_err_o, 5'b10000);
        chk("tmo.hit.isolate", isolate_o, 5'b00000);
        tick(3);
        chk_all("tmo.blocked", 5'b00000, 5'b11111, 5'b00000);
        chk("tmo.sticky.err", timeout_err_o, 5'b10000);
        rst_ni = 1'b0;
        tick();
        chk("tmo.reset.err", timeout_err_o, 5'b00000);
        rst_ni = 1'b1;
        gate_req_i = 5'b00000;
        tick();
`else
        chk("no_tmo.err", timeout_err_o, 5'b00000);
`endif

        // Asynchronous reset while cluster 2 is gated
        gate_req_i = 5'b00100;
        tick(2);
        chk("mid_reset.pre.clk_en", clk_en_o, 5'b11011);
        #2 rst_ni = 1'b0;
        #1;
        chk_all("mid_reset.async", 5'b00000, 5'b11111, 5'b00000);
        gate_req_i = 5'b00000;
        tick();
        rst_ni = 1'b1;
        tick();
        chk_all("mid_reset.after", 5'b00000, 5'b11111, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
